// File: rtl/delay_echo_fb.sv
// Programmable-delay echo: y[n] = sat(x[n] + g*buf[n-D]), fixed 2-cycle latency, no backpressure.
// DELAY_ECHO_FEEDBACK_EN: buffer stores y (recursive echo); otherwise it stores x (single echo).
module delay_echo_fb #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 128,
  parameter int GAIN_WIDTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  input  logic signed [DATA_WIDTH-1:0]  i_data,
  input  logic [$clog2(DEPTH)-1:0]      i_delay,
  input  logic [GAIN_WIDTH-1:0]         i_gain,
  output logic                          o_valid,
  output logic signed [DATA_WIDTH-1:0]  o_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]                wr_ptr;
  logic [AW-1:0]                fill;
  logic [AW-1:0]                rd_idx;

  logic                         s1_vld;
  logic                         s1_use;
  logic                         s1_fwd;
  logic signed [DATA_WIDTH-1:0] s1_x;
  logic signed [DATA_WIDTH-1:0] s1_ram;
  logic signed [DATA_WIDTH-1:0] s1_fwd_dat;
  logic [GAIN_WIDTH-1:0]        s1_gain;
  logic [AW-1:0]                s1_slot;

  logic signed [DATA_WIDTH-1:0] dly;
  logic signed [PW-1:0]         d_ext;
  logic signed [PW-1:0]         g_ext;
  logic signed [PW-1:0]         prod;
  logic signed [DATA_WIDTH:0]   echo;
  logic signed [DATA_WIDTH:0]   sum;
  logic signed [DATA_WIDTH-1:0] y;
  logic signed [DATA_WIDTH-1:0] store;
  logic                         unused_prod_lsb;

  assign rd_idx = wr_ptr - i_delay;

  // Taking the upper DATA_WIDTH+1 product bits is the floor shift by GAIN_WIDTH.
  assign dly   = s1_use ? (s1_fwd ? s1_fwd_dat : s1_ram) : '0;
  assign d_ext = {{(GAIN_WIDTH+1){dly[DATA_WIDTH-1]}}, dly};
  assign g_ext = {{(DATA_WIDTH+1){1'b0}}, s1_gain};
  assign prod  = d_ext * g_ext;
  assign echo  = prod[PW-1:GAIN_WIDTH];
  assign sum   = {s1_x[DATA_WIDTH-1], s1_x} + echo;
  assign unused_prod_lsb = ^prod[GAIN_WIDTH-1:0];

  always_comb begin
    y = sum[DATA_WIDTH-1:0];
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
      y = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                          : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

`ifdef DELAY_ECHO_FEEDBACK_EN
  assign store = y;
`else
  assign store = s1_x;
`endif

  // Buffer: stage-2 write, stage-1 registered read (stale read-during-write value is bypassed).
  always_ff @(posedge i_clk) begin
    if (s1_vld) begin
      mem[s1_slot] <= store;
    end
    if (i_valid) begin
      s1_ram <= mem[rd_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      s1_x       <= i_data;
      s1_gain    <= i_gain;
      s1_slot    <= wr_ptr;
      s1_use     <= (i_delay != '0) && (fill >= i_delay);
      s1_fwd     <= s1_vld && (s1_slot == rd_idx);
      s1_fwd_dat <= store;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      fill    <= '0;
      s1_vld  <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      s1_vld  <= i_valid;
      o_valid <= s1_vld;
      if (i_valid) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (fill != AW'(DEPTH - 1)) begin
          fill <= fill + AW'(1);
        end
      end
      if (s1_vld) begin
        o_data <= y;
      end
    end
  end

endmodule

// File: tb/tb_delay_echo_fb.sv
// Bench for delay_echo_fb: directed test-plan steps plus random traffic against a sample-history model.
module tb_delay_echo_fb;

  localparam int DW    = 16;
  localparam int DEPTH = 128;
  localparam int GW    = 8;
  localparam int AW    = $clog2(DEPTH);

  logic                 clk = 1'b0;
  logic                 i_rst = 1'b1;
  logic                 i_valid = 1'b0;
  logic signed [DW-1:0] i_data = '0;
  logic [AW-1:0]        i_delay = '0;
  logic [GW-1:0]        i_gain = '0;
  logic                 o_valid;
  logic signed [DW-1:0] o_data;

  int compared = 0;
  int mismatched = 0;

  // Stored value of every sample accepted since the last reset, oldest first.
  int hist[$];
  bit pend_v = 1'b0;
  int pend_y = 0;

  always #5 clk = ~clk;

  delay_echo_fb #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .GAIN_WIDTH(GW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .i_delay(i_delay), .i_gain(i_gain), .o_valid(o_valid), .o_data(o_data)
  );

  task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    compared++;
    assert (act === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input bit v, input int x, input int dl, input int g, input bit rst);
    bit cv;
    int cy, d, e, s, n;
    cv = 1'b0;
    cy = 0;
    i_rst = rst; i_valid = v; i_data = x[DW-1:0]; i_delay = dl[AW-1:0]; i_gain = g[GW-1:0];
    if (v && !rst) begin
      n = hist.size();
      d = (dl != 0 && n >= dl) ? hist[n - dl] : 0;
      e = (d * g) >>> GW;
      s = x + e;
      cy = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
`ifdef DELAY_ECHO_FEEDBACK_EN
      hist.push_back(cy);
`else
      hist.push_back(x);
`endif
      cv = 1'b1;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      hist.delete();
      chk("rst_valid", {31'd0, o_valid}, 0);
      chk("rst_data", o_data, 0);
      pend_v = 1'b0;
    end else begin
      chk("valid", {31'd0, o_valid}, {31'd0, pend_v});
      if (pend_v) chk("data", o_data, pend_y);
      pend_v = cv;
      pend_y = cy;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    step(1'b0, 0, 0, 0, 1'b1);
    step(1'b0, 0, 0, 0, 1'b1);
    idle(1);

    // Impulse, D=4, gain 1/2
    step(1'b1, 1000, 4, 128, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 0, 4, 128, 1'b0);
    idle(2);

    // Back-to-back D=1 exercises the write-to-read bypass
    step(1'b1, 0, 0, 0, 1'b1);
    step(1'b1, 1000, 1, 128, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 0, 1, 128, 1'b0);
    idle(2);

    // Saturation both rails
    step(1'b0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 30000, 1, 255, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, -30000, 1, 255, 1'b0);
    idle(2);

    // Fill mask: no echo before D samples have been seen; D=0 passes x through
    step(1'b0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 126; i++) step(1'b1, 100, 127, 255, 1'b0);
    step(1'b1, -7, 0, 255, 1'b0);
    idle(2);

    // Sparse valids: delay counts samples, not cycles
    step(1'b0, 0, 0, 0, 1'b1);
    step(1'b1, 1000, 2, 128, 1'b0);
    idle(2);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 0, 2, 128, 1'b0);
      idle(2);
    end

    // Reset with samples in flight, then an impulse must show no stale echo
    step(1'b1, 500, 2, 128, 1'b0);
    step(1'b1, 600, 2, 128, 1'b0);
    step(1'b1, 700, 2, 128, 1'b1);
    step(1'b1, 1000, 2, 128, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 0, 2, 128, 1'b0);
    idle(2);

    // Random traffic: dense short delays, then full-range delay/gain, gaps and rare resets
    for (int i = 0; i < 200; i++)
      step(1'b1, int'($urandom_range(65535)) - 32768, int'($urandom_range(3)),
           int'($urandom_range(255)), 1'b0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(3) != 0, int'($urandom_range(65535)) - 32768,
           int'($urandom_range(DEPTH - 1)), int'($urandom_range(255)),
           $urandom_range(199) == 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/delay_echo_fb.md
Name: delay_echo_fb

Overview:
Parametrised audio echo stage for the sample-stream path.
- Adds an attenuated, sample-delayed copy of the signal to each incoming sample.
- Delay (in samples) and gain are programmable at run time.
- Uses a circular sample buffer with full-rate forwarding.
- Supersedes the fixed one-cycle echo stage; sits between the sample source and the output/compare logic.

Parameters:
DATA_WIDTH, 16, sample width; signed two's complement on input and output
DEPTH, 128, buffer depth in samples; power of two; maximum delay is DEPTH-1
GAIN_WIDTH, 8, gain width; unsigned fraction, gain = i_gain / 2^GAIN_WIDTH

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_valid  in  1  input sample strobe; may be high every cycle
i_data  in  DATA_WIDTH  signed input sample x[n]
i_delay  in  $clog2(DEPTH)  echo delay D in samples, sampled with each accepted sample
i_gain  in  GAIN_WIDTH  echo gain, sampled with each accepted sample
o_valid  out  1  output sample strobe
o_data  out  DATA_WIDTH  signed output sample y[n]

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - o_valid=0, o_data=0, write pointer=0, fill counter=0.
  - Pipeline valids are cleared; in-flight samples are discarded.
  - Buffer RAM is not cleared; the fill counter masks stale contents.
- Sample accept: on any cycle with i_valid=1 and i_rst=0. There is no backpressure.
- Delay is measured in accepted samples, not cycles. Idle cycles do not advance the pointer.
- Pipeline, fixed latency 2:
  - Stage 1 (accept edge): register x, D and gain. Read buf[(wr_ptr - D) mod DEPTH]. Increment wr_ptr mod DEPTH. Increment fill (saturating at DEPTH-1).
  - Stage 2: compute y. Write the stored value to buf[slot of this sample]. Drive o_data=y and o_valid=1 on the following edge.
- Delay mask: delayed term d = 0 if D == 0 or fill (before this sample) < D; otherwise d = buffer read.
- Arithmetic:
  - p = d * {0, gain}, signed, DATA_WIDTH+GAIN_WIDTH+1 bits.
  - e = p >>> GAIN_WIDTH (arithmetic shift, rounds toward -inf).
  - s = x + e, in DATA_WIDTH+1 bits.
  - y = s saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Stored value: y with the feature macro defined; x without it.
- Forwarding: with D=1 and back-to-back valids, the stage-1 read targets the slot being written by stage 2. The stage-2 write value must be forwarded. The RAM read-during-write value must not be used.
- D or gain change mid-stream: takes effect from the next accepted sample. No glitch, no flush.
- Pointer wrap: wr_ptr wraps DEPTH-1 -> 0. Read index uses modulo-DEPTH subtraction.
- Reset mid-operation: o_valid=0 from the first edge with i_rst=1. After release, the first DEPTH-1 samples see echo only from post-reset samples.

Optional Feature:
Macro: DELAY_ECHO_FEEDBACK_EN
- Defined: recursive echo. The buffer stores y, so the echo decays geometrically: y[n] = sat(x[n] + g*y[n-D]).
- Undefined: single feed-forward echo. The buffer stores x: y[n] = sat(x[n] + g*x[n-D]).
- Latency, ports and forwarding are identical in both builds. With the macro undefined, the forward path carries x.

Test Plan:
- Impulse, feedback build: D=4, gain=128; x=1000 then 0s, back-to-back -> o_data 1000,0,0,0,500,0,0,0,250,0,0,0,125; each o_valid 2 cycles after its i_valid.
- Impulse, feed-forward build: same stimulus -> 1000,0,0,0,500 then all 0.
- Full-rate D=1 forwarding, feedback build: gain=128, x=1000,0,0,0 -> 1000,500,250,125.
- Saturation: D=1, gain=255, x=30000 constant -> o_data 30000, then clamps at 32767. Repeat with x=-30000 -> clamps at -32768.
- Fill mask and delay 0: after reset, D=127, 126 impulses of 100 -> every output 100, no echo. D=0, x=-7 -> o_data=-7.
- Sparse valids and reset: valids every 3rd cycle, D=2 -> echo after 2 samples, not cycles. Assert i_rst for 1 cycle with samples in flight -> o_valid=0 on the next 2 edges, and the next impulse shows no echo from pre-reset data.
